// File: rtl/conv_pool_pkg.sv
// conv_pool_pkg: shared widths, FSM state and tile/kernel helpers.
// Imported by conv3x3_ch and the conv_pool top.
package conv_pool_pkg;

  localparam int PIX_W  = 8;
  localparam int TILE_W = 128;
  localparam int KERN_W = 72;
  localparam int ACC_W  = 22;
  localparam int PROD_W = 2*PIX_W + 1;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } state_t;

  function automatic logic [PIX_W-1:0] tile_pix(
    input logic [TILE_W-1:0] t,
    input int p
  );
    return t[TILE_W-1-PIX_W*p -: PIX_W];
  endfunction

  function automatic logic signed [PIX_W-1:0] kern_w(
    input logic [KERN_W-1:0] k,
    input int n
  );
    return k[KERN_W-1-PIX_W*n -: PIX_W];
  endfunction

endpackage

// File: rtl/conv3x3_ch.sv
// conv3x3_ch: one channel of the 3x3 valid convolution on a 4x4 tile.
// Products are registered; the four 2x2 tap sums are combinational.
module conv3x3_ch
  import conv_pool_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TILE_W-1:0] tile,
  input  logic [KERN_W-1:0] kernel,
  output logic [4*ACC_W-1:0] psum
);

  logic signed [PROD_W-1:0] prod_d [4][9];
  logic signed [PROD_W-1:0] prod   [4][9];
  logic signed [ACC_W-1:0]  acc;

  // output o = 2*oy + ox, tap k = 3*i + j
  always_comb begin
    for (int o = 0; o < 4; o++)
      for (int k = 0; k < 9; k++)
        prod_d[o][k] =
          PROD_W'($signed({1'b0,
            tile_pix(tile, 4*(o/2 + k/3) + o%2 + k%3)}))
          * PROD_W'(kern_w(kernel, k));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < 4; o++)
        for (int k = 0; k < 9; k++)
          prod[o][k] <= '0;
    end else begin
      for (int o = 0; o < 4; o++)
        for (int k = 0; k < 9; k++)
          prod[o][k] <= prod_d[o][k];
    end
  end

  always_comb begin
    psum = '0;
    acc  = '0;
    for (int o = 0; o < 4; o++) begin
      acc = '0;
      for (int k = 0; k < 9; k++)
        acc = acc + ACC_W'(prod[o][k]);
      psum[ACC_W*o +: ACC_W] = acc;
    end
  end

endmodule

// File: rtl/conv_pool.sv
// conv_pool: 3-channel 3x3 conv + 2x2 max-pool streaming engine.
// Optional CONV_POOL_DONE_EN adds a sticky done output.
module conv_pool
  import conv_pool_pkg::*;
#(
  parameter int NUM_BLOCKS = 65025,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TILE_W-1:0] image_4x4_r,
  input  logic [TILE_W-1:0] image_4x4_g,
  input  logic [TILE_W-1:0] image_4x4_b,
  input  logic [KERN_W-1:0] kernel_r,
  input  logic [KERN_W-1:0] kernel_g,
  input  logic [KERN_W-1:0] kernel_b,
  output logic              input_re,
  output logic [ADDR_W-1:0] input_addr,
  output logic              output_we,
  output logic [ADDR_W-1:0] output_addr,
  output logic [PIX_W-1:0]  y
`ifdef CONV_POOL_DONE_EN
  ,
  output logic              done
`endif
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_BLOCKS - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX = 255;

  state_t state;

  logic              v_mem, v_mul, v_sum;
  logic [ADDR_W-1:0] a_mem, a_mul, a_sum;

  logic [4*ACC_W-1:0]      ps_r, ps_g, ps_b;
  logic signed [ACC_W-1:0] s [4];
  logic signed [ACC_W-1:0] m;

  conv3x3_ch u_r (
    .clk    (clk),
    .rst_n  (rst),
    .tile   (image_4x4_r),
    .kernel (kernel_r),
    .psum   (ps_r)
  );

  conv3x3_ch u_g (
    .clk    (clk),
    .rst_n  (rst),
    .tile   (image_4x4_g),
    .kernel (kernel_g),
    .psum   (ps_g)
  );

  conv3x3_ch u_b (
    .clk    (clk),
    .rst_n  (rst),
    .tile   (image_4x4_b),
    .kernel (kernel_b),
    .psum   (ps_b)
  );

  // input_re low while in RUN only on the first cycle after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      input_re   <= 1'b0;
      input_addr <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (!input_re) begin
            input_re <= 1'b1;
          end else if (input_addr == LAST) begin
            input_re <= 1'b0;
            state    <= DRAIN;
          end else begin
            input_addr <= input_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (!v_mem && !v_mul && !v_sum)
            state <= DONE;
        end
        DONE:    state <= DONE;
        default: state <= DONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_mem <= 1'b0;
      v_mul <= 1'b0;
      v_sum <= 1'b0;
      a_mem <= '0;
      a_mul <= '0;
      a_sum <= '0;
    end else begin
      v_mem <= input_re;
      v_mul <= v_mem;
      v_sum <= v_mul;
      a_mem <= input_addr;
      a_mul <= a_mem;
      a_sum <= a_mul;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < 4; o++)
        s[o] <= '0;
    end else begin
      for (int o = 0; o < 4; o++)
        s[o] <= $signed(ps_r[ACC_W*o +: ACC_W])
              + $signed(ps_g[ACC_W*o +: ACC_W])
              + $signed(ps_b[ACC_W*o +: ACC_W]);
    end
  end

  always_comb begin
    m = s[0];
    for (int o = 1; o < 4; o++)
      if (s[o] > m)
        m = s[o];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      output_we   <= 1'b0;
      output_addr <= '0;
      y           <= '0;
    end else begin
      output_we   <= v_sum;
      output_addr <= a_sum;
      unique case (1'b1)
        m[ACC_W-1]:  y <= '0;
        (m > Y_MAX): y <= 8'hff;
        default:     y <= m[PIX_W-1:0];
      endcase
    end
  end

`ifdef CONV_POOL_DONE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      done <= 1'b0;
    else if (output_we && output_addr == LAST)
      done <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_conv_pool.sv
// tb_conv_pool: directed checks of conv_pool with a behavioural
// image memory and a reference conv/pool model for the full run.
module tb_conv_pool;

  localparam int N = 65025;

  logic         clk_tb = 1'b0;
  logic         rst;
  logic [127:0] image_4x4_r, image_4x4_g, image_4x4_b;
  logic [71:0]  kernel_r, kernel_g, kernel_b;
  logic         input_re, output_we;
  logic [15:0]  input_addr, output_addr;
  logic [7:0]   y;
`ifdef CONV_POOL_DONE_EN
  logic         done;
`endif

  int checks = 0;
  int errors = 0;

  int           tmode = 0;
  logic [127:0] tile_c [3];

  always #5 clk_tb = ~clk_tb;

  conv_pool dut (
    .clk         (clk_tb),
    .rst         (rst),
    .image_4x4_r (image_4x4_r),
    .image_4x4_g (image_4x4_g),
    .image_4x4_b (image_4x4_b),
    .kernel_r    (kernel_r),
    .kernel_g    (kernel_g),
    .kernel_b    (kernel_b),
    .input_re    (input_re),
    .input_addr  (input_addr),
    .output_we   (output_we),
    .output_addr (output_addr),
    .y           (y)
`ifdef CONV_POOL_DONE_EN
    ,
    .done        (done)
`endif
  );

  function automatic logic [7:0] pix_of(int ch, int addr, int p);
    logic [127:0] t;
    if (tmode == 0) begin
      t = tile_c[ch];
      return t[127-8*p -: 8];
    end
    return 8'((addr*7 + p*13 + ch*29 + (addr >> 8)*3) & 255);
  endfunction

  function automatic logic [127:0] tile_of(int ch, int addr);
    logic [127:0] t;
    t = '0;
    for (int p = 0; p < 16; p++)
      t[127-8*p -: 8] = pix_of(ch, addr, p);
    return t;
  endfunction

  function automatic int gold_y(int addr);
    int m, s, w;
    logic [71:0] k;
    m = -1000000;
    for (int oy = 0; oy < 2; oy++)
      for (int ox = 0; ox < 2; ox++) begin
        s = 0;
        for (int ch = 0; ch < 3; ch++) begin
          k = (ch == 0) ? kernel_r :
              (ch == 1) ? kernel_g : kernel_b;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
              w = int'($signed(k[71-8*(3*i+j) -: 8]));
              s += int'(pix_of(ch, addr,
                          4*(oy+i) + ox + j)) * w;
            end
        end
        if (s > m) m = s;
      end
    return (m < 0) ? 0 : ((m > 255) ? 255 : m);
  endfunction

  // synchronous image memory, reads 0 when not enabled
  always @(posedge clk_tb) begin
    if (input_re) begin
      image_4x4_r <= tile_of(0, int'(input_addr));
      image_4x4_g <= tile_of(1, int'(input_addr));
      image_4x4_b <= tile_of(2, int'(input_addr));
    end else begin
      image_4x4_r <= '0;
      image_4x4_g <= '0;
      image_4x4_b <= '0;
    end
  end

  task automatic do_reset;
    @(negedge clk_tb);
    rst = 1'b0;
    repeat (2) @(negedge clk_tb);
    rst = 1'b1;
  endtask

  task automatic wait_first_write(output int lat);
    int first_rd;
    first_rd = -1;
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_tb);
      if (input_re && first_rd < 0) first_rd = c;
      if (output_we) begin
        lat = (first_rd < 0) ? -2 : c - first_rd;
        return;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({input_re, output_we} !== 2'b00) begin
      errors++;
      $display("FAIL reset_strobes got re=%b we=%b want 0 0",
               input_re, output_we);
    end
    checks++;
    if ({input_addr, output_addr, y} !== 40'h0) begin
      errors++;
      $display("FAIL reset_values got ia=%0d oa=%0d y=%0d want 0",
               input_addr, output_addr, y);
    end
    repeat (3) @(negedge clk_tb);
    checks++;
    if (input_re !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got re=%b want 0", input_re);
    end
  endtask

  task automatic test_identity;
    int lat;
    tmode = 0;
    kernel_r = 72'h00000000_01_00000000;
    kernel_g = 72'h00000000_01_00000000;
    kernel_b = 72'h00000000_01_00000000;
    tile_c[0] = 128'h0102030405060708090a0b0c0d0e0f10;
    tile_c[1] = '0;
    tile_c[2] = '0;
    do_reset();
    wait_first_write(lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL identity_latency got %0d want 4", lat);
    end
    checks++;
    if (y !== 8'd11 || output_addr !== 16'd0) begin
      errors++;
      $display("FAIL identity_y got y=%0d a=%0d want 11 0",
               y, output_addr);
    end
  endtask

  task automatic test_back_to_back;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk_tb);
      checks++;
      if (output_we !== 1'b1 || output_addr !== 16'(k)
          || y !== 8'd11) begin
        errors++;
        $display("FAIL b2b_%0d got we=%b a=%0d y=%0d want 1 %0d 11",
                 k, output_we, output_addr, y, k);
      end
    end
  endtask

  task automatic test_clamp_high;
    int lat;
    tmode = 0;
    kernel_r = 72'h010101010101010101;
    kernel_g = 72'h010101010101010101;
    kernel_b = 72'h010101010101010101;
    for (int c = 0; c < 3; c++) tile_c[c] = '1;
    do_reset();
    wait_first_write(lat);
    checks++;
    if (lat !== 4 || y !== 8'd255) begin
      errors++;
      $display("FAIL clamp_high got lat=%0d y=%0d want 4 255",
               lat, y);
    end
  endtask

  task automatic test_clamp_low;
    int lat;
    tmode = 0;
    kernel_r = '1;
    kernel_g = '1;
    kernel_b = '1;
    for (int c = 0; c < 3; c++)
      tile_c[c] = {16{8'h10}};
    do_reset();
    wait_first_write(lat);
    checks++;
    if (lat !== 4 || y !== 8'd0) begin
      errors++;
      $display("FAIL clamp_low got lat=%0d y=%0d want 4 0",
               lat, y);
    end
  endtask

  task automatic test_layout;
    int lat;
    tmode = 0;
    kernel_r = 72'h02_0000000000000000;
    kernel_g = '0;
    kernel_b = '0;
    tile_c[0] = 128'h00300000_00000000_00000000_00000000;
    tile_c[1] = '0;
    tile_c[2] = '0;
    do_reset();
    wait_first_write(lat);
    checks++;
    if (lat !== 4 || y !== 8'd96) begin
      errors++;
      $display("FAIL layout got lat=%0d y=%0d want 4 96",
               lat, y);
    end
  endtask

  task automatic set_run_kernels;
    tmode = 1;
    kernel_r = 72'h01FF00_0200FE_0001FF;
    kernel_g = 72'h000100_FF01FF_000100;
    kernel_b = 72'h010000_000000_0000FF;
  endtask

  task automatic test_reset_mid_run;
    bit hit;
    int g0;
    set_run_kernels();
    do_reset();
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk_tb);
      if (input_re && input_addr == 16'd100) hit = 1;
    end
    checks++;
    if (!hit || output_we !== 1'b1 || output_addr !== 16'd96) begin
      errors++;
      $display("FAIL midrun_inflight got hit=%0d we=%b a=%0d want 1 1 96",
               hit, output_we, output_addr);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (output_we !== 1'b0 || input_re !== 1'b0
        || output_addr !== 16'd0 || input_addr !== 16'd0) begin
      errors++;
      $display("FAIL midrun_drop got we=%b re=%b oa=%0d ia=%0d want 0",
               output_we, input_re, output_addr, input_addr);
    end
    repeat (2) @(negedge clk_tb);
    rst = 1'b1;
    @(negedge clk_tb);
    checks++;
    if (input_re !== 1'b1 || input_addr !== 16'd0) begin
      errors++;
      $display("FAIL midrun_restart got re=%b ia=%0d want 1 0",
               input_re, input_addr);
    end
    for (int c = 1; c < 4; c++) begin
      @(negedge clk_tb);
      checks++;
      if (output_we !== 1'b0) begin
        errors++;
        $display("FAIL midrun_stale_%0d got we=%b want 0",
                 c, output_we);
      end
    end
    @(negedge clk_tb);
    g0 = gold_y(0);
    checks++;
    if (output_we !== 1'b1 || output_addr !== 16'd0
        || y !== 8'(g0)) begin
      errors++;
      $display("FAIL midrun_first got we=%b a=%0d y=%0d want 1 0 %0d",
               output_we, output_addr, y, g0);
    end
  endtask

  task automatic test_full_run;
    int first_rd, first_wr, last_wr;
    int exp_rd, exp_wr, rd_bad, tail_bad, g;
    first_rd = -1;
    first_wr = -1;
    last_wr  = -1;
    exp_rd   = 0;
    exp_wr   = 0;
    rd_bad   = 0;
    tail_bad = 0;
    set_run_kernels();
    do_reset();
    for (int c = 0; c < N + 40 && exp_wr < N; c++) begin
      @(negedge clk_tb);
      if (input_re) begin
        if (first_rd < 0) first_rd = c;
        if (input_addr !== 16'(exp_rd)) rd_bad++;
        exp_rd++;
      end
      if (output_we) begin
        if (first_wr < 0) first_wr = c;
        g = gold_y(exp_wr);
        checks++;
        if (output_addr !== 16'(exp_wr) || y !== 8'(g)) begin
          errors++;
          $display("FAIL tile got a=%0d y=%0d want %0d %0d",
                   output_addr, y, exp_wr, g);
        end
        exp_wr++;
        if (exp_wr == N) last_wr = c;
      end
    end
    checks++;
    if (exp_wr != N) begin
      errors++;
      $display("FAIL run_timeout got %0d writes want %0d", exp_wr, N);
    end
    checks++;
    if (exp_rd != N || rd_bad != 0) begin
      errors++;
      $display("FAIL read_seq got %0d reads %0d bad want %0d 0",
               exp_rd, rd_bad, N);
    end
    checks++;
    if (first_wr - first_rd != 4) begin
      errors++;
      $display("FAIL first_latency got %0d want 4",
               first_wr - first_rd);
    end
    checks++;
    if (last_wr - first_rd != N + 3) begin
      errors++;
      $display("FAIL last_write got %0d want %0d",
               last_wr - first_rd, N + 3);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_tb);
      if (input_re !== 1'b0 || output_we !== 1'b0) tail_bad++;
    end
    checks++;
    if (tail_bad != 0) begin
      errors++;
      $display("FAIL done_quiet got %0d active cycles want 0",
               tail_bad);
    end
  endtask

  initial begin
    rst = 1'b0;
    kernel_r = '0;
    kernel_g = '0;
    kernel_b = '0;
    for (int c = 0; c < 3; c++) tile_c[c] = '0;
    test_reset();
    test_identity();
    test_back_to_back();
    test_clamp_high();
    test_clamp_low();
    test_layout();
    test_reset_mid_run();
    test_full_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_pool.md
Name: conv_pool

Overview:
- Streaming 3-channel (R/G/B) convolution + max-pool engine.
- Reads one 4x4 pixel tile per channel per cycle from external synchronous image memories.
- Applies a signed 3x3 kernel per channel (valid convolution gives 2x2 outputs) and sums the three channels.
- Max-pools the 2x2 result into one clamped 8-bit value, written to an external result memory at the same index as the tile.

Parameters:
NUM_BLOCKS, 65025, number of tiles processed per run (addresses 0..NUM_BLOCKS-1).
ADDR_W, 16, width of input_addr and output_addr.
PIX_W, 8, pixel and kernel coefficient width.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  reset; asynchronous and active-low (0 = reset).
image_4x4_r  in  128  red 4x4 tile, returned by memory one cycle after request.
image_4x4_g  in  128  green tile, same timing.
image_4x4_b  in  128  blue tile, same timing.
kernel_r  in  72  red 3x3 signed kernel, static during a run.
kernel_g  in  72  green kernel.
kernel_b  in  72  blue kernel.
input_re  out  1  image read enable (shared by all three memories).
input_addr  out  16  tile index to read.
output_we  out  1  result write strobe.
output_addr  out  16  result index.
y  out  8  result byte.

Behaviour:
- Tile layout: pixel p = 4*row + col, unsigned, at bits [127-8p -: 8] (pixel 0 in the MSBs).
- Kernel layout: weight k = 3*i + j, two's-complement signed, at bits [71-8k -: 8].
- Memory model: when input_re = 1 at a rising edge, the tile for input_addr appears on image_4x4_* after that edge. When input_re = 0, the inputs read 0.
- Convolution, per output (oy, ox) in {0,1}^2: S(oy,ox) = sum over the three channels and i,j in 0..2 of pix[oy+i][ox+j] * w[i][j].
  - Pixels are zero-extended; weights are sign-extended.
  - Accumulate at a minimum of 22 signed bits, so there is no overflow (27 products of 17 bits each).
- Pool: M = max of the four S values (signed compare).
- Output: y = 0 if M < 0; y = 255 if M > 255; otherwise y = M[7:0].
- FSM:
  - RUN is entered on the first edge after rst deasserts.
  - In RUN, input_re = 1 and input_addr increments 0,1,...,NUM_BLOCKS-1, one per cycle.
  - After the last address, go to DRAIN: input_re = 0 and the pipeline empties.
  - Then DONE: all strobes stay 0 until the next reset.
- Pipeline:
  - Memory read edge, then the multiply register stage, then the channel/tap sum register stage, then the pool/clamp register stage driving y.
  - output_we for tile A is asserted exactly 4 rising edges after the edge that sampled input_re = 1 with input_addr = A.
  - output_addr carries A, delayed with the data through a valid/address shift pipeline.
- Throughput: one result per cycle, no bubbles. The final write occurs NUM_BLOCKS+3 cycles after the first read.
- Reset values: input_re = 0, input_addr = 0, output_we = 0, output_addr = 0, y = 0; all pipeline valid bits are cleared.
- Reset mid-run: every in-flight tile is discarded with no write. After release, the run restarts at address 0.
- Kernel inputs are sampled in the multiply stage each cycle; changing them mid-run affects later tiles only.

Optional Feature:
CONV_POOL_DONE_EN
- Defined: adds output port done (1 bit, reset 0). It goes high the cycle after the final output_we and stays high until reset.
- Undefined: no done port; the behaviour of all other ports is identical.

Decomposition:
- Package conv_pool_pkg holds:
  - the PIX_W, tile width 128 and kernel width 72 constants;
  - the ACC_W = 22 constant;
  - the FSM state enum (RUN, DRAIN, DONE);
  - a tile-pixel extraction function.
- Sub-module conv3x3_ch: one channel, producing four signed 2x2 valid-convolution partial sums from a tile and a kernel. It is instantiated three times. The top level sums the channels, pools, clamps and runs the FSM and address pipeline.

Test Plan:
- All kernels = identity (w[1][1] = 1, others 0, i.e. 72'h00000000_01_00000000); R tile pixels 0x01..0x10, G/B = 0 -> S = {6,7,10,11}, y = 11 (0x0B).
- All weights = 1 (72'h010101010101010101); all pixels 0xFF -> S = 27*255 = 6885, y = 255 (clamp high).
- All weights = -1 (0xFF); all pixels 0x10 -> M = -432, y = 0 (clamp low).
- Only kernel_r[0][0] = 2; tile R pixel(0,1) = 0x30, other pixels 0 -> S(0,0)=0, S(0,1)=96, y = 96 (0x60); verifies layout/order.
- Timing/addresses: after reset release, output_we first rises 4 edges after the first read. Across 65025 tiles, check output_addr increments 0..65024 with no gaps, then input_re and output_we stay 0.
- Assert rst mid-run at address 100 -> output_we drops immediately. After release, reads and writes restart at address 0; full golden comparison of results then passes.
